// File: rtl/pht_update_scheduler.sv
// PHT write sequencer: a post-reset init sweep, then in-order issue of queued
// counter updates to two RAM write ports without ever colliding on a bank.
module pht_update_scheduler #(
  parameter int unsigned ENTRY_NUM   = 1024,
  parameter int unsigned INDEX_WIDTH = $clog2(ENTRY_NUM),
  parameter int unsigned DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = 16'hAAAA,
  parameter int unsigned REQ_NUM     = 2,
  parameter int unsigned BANK_NUM    = 2,
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            reqValid,
  input  logic [INDEX_WIDTH-1:0]        reqAddr [REQ_NUM],
  input  logic [DATA_WIDTH-1:0]         reqData [REQ_NUM],
  output logic                          reqReady,
  output logic [REQ_NUM-1:0]            we,
  output logic [INDEX_WIDTH-1:0]        wa [REQ_NUM],
  output logic [DATA_WIDTH-1:0]         wv [REQ_NUM],
  output logic                          initBusy,
  output logic [$clog2(QUEUE_DEPTH):0]  pendingCount,
  output logic [7:0]                    dropCount
);

  localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  typedef enum logic {stInit, stRun} state_t;

  state_t                 state, stateNext;
  logic [INDEX_WIDTH-1:0] initPtr;
  logic [INDEX_WIDTH-1:0] qAddr [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  qData [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rdPtr, wrPtr, rdPtrNext;
  logic [CNT_W-1:0]       count;
  logic                   sameAddr, take0, take1, issue0, issue1;
  logic [1:0]             enqNum, deqNum, dropNum;
  logic [8:0]             dropSum;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= stInit;
    else     state <= stateNext;
  end

  // FSM next state: leave INIT once the last pair of the sweep is written
  always_comb begin
    stateNext = state;
    if ((state == stInit) && (initPtr == INDEX_WIDTH'(ENTRY_NUM - 2))) stateNext = stRun;
  end

  // Issue decision from the queue head; the second slot only if it is in the other bank
  always_comb begin
    rdPtrNext = rdPtr + PTR_W'(1);
    issue0    = ~rst & (state == stRun) & (count != '0);
    issue1    = issue0 & (count >= CNT_W'(2)) &
                (qAddr[rdPtrNext][BANK_W-1:0] != qAddr[rdPtr][BANK_W-1:0]);
    deqNum    = 2'(issue0) + 2'(issue1);
  end

  // Enqueue/drop decision; a same-address pair keeps only the younger port 1 update
  always_comb begin
    sameAddr = reqValid[0] & reqValid[1] & (reqAddr[0] == reqAddr[1]);
    take0    = reqReady & reqValid[0] & ~sameAddr;
    take1    = reqReady & reqValid[1];
    enqNum   = 2'(take0) + 2'(take1);
    dropNum  = reqReady ? 2'd0 : (2'(reqValid[0]) + 2'(reqValid[1]));
    dropSum  = 9'(dropCount) + 9'(dropNum);
  end

  // FSM outputs: sweep writes in INIT, queue-head writes in RUN, all quiet in reset
  always_comb begin
    reqReady     = 1'b0;
    we           = '0;
    wa[0]        = '0;
    wa[1]        = '0;
    wv[0]        = '0;
    wv[1]        = '0;
    initBusy     = 1'b1;
    pendingCount = '0;
    if (!rst) begin
      pendingCount = count;
      if (state == stInit) begin
        we    = 2'b11;
        wa[0] = initPtr;
        wa[1] = initPtr + INDEX_WIDTH'(1);
        wv[0] = INIT_VALUE;
        wv[1] = INIT_VALUE;
      end else begin
        initBusy = 1'b0;
        reqReady = (count <= CNT_W'(QUEUE_DEPTH - 2));
        we       = {issue1, issue0};
        if (issue0) begin
          wa[0] = qAddr[rdPtr];
          wv[0] = qData[rdPtr];
        end
        if (issue1) begin
          wa[1] = qAddr[rdPtrNext];
          wv[1] = qData[rdPtrNext];
        end
      end
    end
  end

  // Sweep pointer, queue pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      initPtr   <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      dropCount <= '0;
    end else begin
      if (state == stInit) initPtr <= initPtr + INDEX_WIDTH'(2);
      rdPtr     <= rdPtr + PTR_W'(deqNum);
      wrPtr     <= wrPtr + PTR_W'(enqNum);
      count     <= count + CNT_W'(enqNum) - CNT_W'(deqNum);
      dropCount <= dropSum[8] ? 8'hFF : dropSum[7:0];
    end
  end

  // Queue storage, filled in port order at the write pointer
  always_ff @(posedge clk) begin
    if (take0) begin
      qAddr[wrPtr] <= reqAddr[0];
      qData[wrPtr] <= reqData[0];
    end
    if (take1) begin
      qAddr[wrPtr + PTR_W'(take0)] <= reqAddr[1];
      qData[wrPtr + PTR_W'(take0)] <= reqData[1];
    end
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Scoreboard bench for pht_update_scheduler with a queue-level reference model.
module tb_pht_update_scheduler;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IW      = 4;
  localparam int unsigned DW      = 16;
  localparam int unsigned QD      = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    reqValid = '0;
  logic [IW-1:0] reqAddr [2];
  logic [DW-1:0] reqData [2];
  logic          reqReady;
  logic [1:0]    we;
  logic [IW-1:0] wa [2];
  logic [DW-1:0] wv [2];
  logic          initBusy;
  logic [3:0]    pendingCount;
  logic [7:0]    dropCount;

  typedef struct packed {
    logic [IW-1:0] addr;
    logic [DW-1:0] data;
  } upd_t;

  upd_t modelQ[$];
  upd_t scoreQ[$];
  upd_t monEntry;
  bit   monOn = 1'b0;
  int   dropModel = 0;
  int   checks = 0;
  int   failures = 0;

  logic [1:0]    rv;
  logic [IW-1:0] ra0, ra1;

  always #5 clk = ~clk;

  pht_update_scheduler #(
    .ENTRY_NUM  (ENTRIES),
    .DATA_WIDTH (DW),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reqValid    (reqValid),
    .reqAddr     (reqAddr),
    .reqData     (reqData),
    .reqReady    (reqReady),
    .we          (we),
    .wa          (wa),
    .wv          (wv),
    .initBusy    (initBusy),
    .pendingCount(pendingCount),
    .dropCount   (dropCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write in RUN must be the oldest outstanding accepted update
  always @(negedge clk) begin
    if (monOn) begin
      for (int p = 0; p < 2; p++) begin
        if (we[p]) begin
          if (scoreQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_write port=%0d actual_addr=%0h expected no write", p, wa[p]);
          end else begin
            monEntry = scoreQ.pop_front();
            chk("write_addr", 64'(wa[p]), 64'(monEntry.addr));
            chk("write_data", 64'(wv[p]), 64'(monEntry.data));
          end
        end
      end
    end
  end

  task automatic doReset(input int cycles);
    @(posedge clk);
    #1;
    monOn    = 1'b0;
    rst      = 1'b1;
    reqValid = '0;
    modelQ.delete();
    scoreQ.delete();
    dropModel = 0;
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_we", 64'(we), 64'(0));
      chk("rst_wa0", 64'(wa[0]), 64'(0));
      chk("rst_wv0", 64'(wv[0]), 64'(0));
      chk("rst_initBusy", 64'(initBusy), 64'(1));
      chk("rst_reqReady", 64'(reqReady), 64'(0));
      chk("rst_pending", 64'(pendingCount), 64'(0));
    end
  endtask

  task automatic initSweep(input bit withDrops);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < ENTRIES / 2; i++) begin
      @(negedge clk);
      chk("init_busy", 64'(initBusy), 64'(1));
      chk("init_we", 64'(we), 64'(3));
      chk("init_wa0", 64'(wa[0]), 64'(2 * i));
      chk("init_wa1", 64'(wa[1]), 64'(2 * i + 1));
      chk("init_wv0", 64'(wv[0]), 64'hAAAA);
      chk("init_wv1", 64'(wv[1]), 64'hAAAA);
      chk("init_reqReady", 64'(reqReady), 64'(0));
      if (withDrops) begin
        reqValid   = 2'($urandom);
        reqAddr[0] = IW'($urandom);
        reqAddr[1] = IW'($urandom);
        dropModel  = dropModel + int'(reqValid[0]) + int'(reqValid[1]);
      end
    end
    @(negedge clk);
    reqValid = '0;
    chk("init_done_busy", 64'(initBusy), 64'(0));
    chk("init_done_ready", 64'(reqReady), 64'(1));
    monOn = 1'b1;
  endtask

  // One RUN cycle at a negedge: check state against the model, retire this
  // cycle's writes from the model, then present new requests.
  task automatic runCycle(input logic [1:0] v, input logic [IW-1:0] a0, input logic [IW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int n;
    bit rdy;
    upd_t e0, e1;
    rdy = (modelQ.size() <= QD - 2);
    chk("reqReady", 64'(reqReady), 64'(rdy));
    chk("pendingCount", 64'(pendingCount), 64'(modelQ.size()));
    chk("dropCount", 64'(dropCount), 64'(dropModel));
    n = 0;
    if (modelQ.size() >= 1) n = 1;
    if (modelQ.size() >= 2 && modelQ[0].addr[0] != modelQ[1].addr[0]) n = 2;
    chk("we_pattern", 64'(we), 64'((n == 2) ? 3 : n));
    repeat (n) void'(modelQ.pop_front());
    reqValid   = v;
    reqAddr[0] = a0;
    reqAddr[1] = a1;
    reqData[0] = d0;
    reqData[1] = d1;
    e0.addr = a0; e0.data = d0;
    e1.addr = a1; e1.data = d1;
    if (rdy) begin
      if (v[0] && !(v[1] && a0 == a1)) begin
        modelQ.push_back(e0);
        scoreQ.push_back(e0);
      end
      if (v[1]) begin
        modelQ.push_back(e1);
        scoreQ.push_back(e1);
      end
    end else begin
      dropModel = dropModel + int'(v[0]) + int'(v[1]);
      if (dropModel > 255) dropModel = 255;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) runCycle(2'b00, '0, '0, '0, '0);
  endtask

  initial begin
    reqAddr[0] = '0; reqAddr[1] = '0;
    reqData[0] = '0; reqData[1] = '0;

    // Reset and first init sweep
    doReset(3);
    initSweep(1'b0);

    // Different banks: both issued together
    runCycle(2'b11, 4'd4, 4'd7, 16'h1111, 16'h2222);
    idle(3);
    // Same bank: issued one per cycle in order
    runCycle(2'b11, 4'd4, 4'd6, 16'h3333, 16'h4444);
    idle(4);
    // Same address: only the younger update survives
    runCycle(2'b11, 4'd5, 4'd5, 16'h0001, 16'h0002);
    idle(3);
    // Same-bank flood until the queue stops accepting, then drain
    for (int k = 0; k < 9; k++)
      runCycle(2'b11, IW'(2 * (k % 4)), IW'(2 * (k % 4) + 8), DW'(16'h5000 + k), DW'(16'h6000 + k));
    idle(10);

    // Randomized traffic with frequent address collisions
    for (int c = 0; c < 300; c++) begin
      rv  = 2'($urandom);
      ra0 = IW'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : IW'($urandom);
      runCycle(rv, ra0, ra1, DW'($urandom), DW'($urandom));
    end
    idle(10);

    // Build a backlog of at least 5, then reset mid-RUN
    for (int k = 0; k < 10 && modelQ.size() < 5; k++)
      runCycle(2'b11, IW'(2 * k % 16), IW'((2 * k + 4) % 16), DW'($urandom), DW'($urandom));
    chk("backlog_before_reset", 64'(pendingCount), 64'(modelQ.size()));
    doReset(2);
    initSweep(1'b1);

    // More random traffic after the restart, then drain
    for (int c = 0; c < 200; c++) begin
      rv  = 2'($urandom);
      ra0 = IW'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : IW'($urandom);
      runCycle(rv, ra0, ra1, DW'($urandom), DW'($urandom));
    end
    for (int c = 0; c < 40 && modelQ.size() != 0; c++) idle(1);
    idle(2);
    chk("scoreboard_drained", 64'(scoreQ.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pht_update_scheduler.md
Name: pht_update_scheduler

Overview:
- Sequences all writes into the banked per-address pattern history table (PAp PHT) RAM.
- After every reset, runs an initialization sweep that writes the weakly-taken init value to every entry.
- Afterwards, accepts resolved-branch counter updates from up to REQ_NUM integer pipes, buffers them in an in-order queue, and issues them to the RAM write ports without bank conflicts.
- Replaces ad-hoc "drop the second write on bank conflict" behaviour: no update is lost unless the producer violates reqReady.

Parameters:
- ENTRY_NUM, 1024, number of PHT entries (power of two).
- INDEX_WIDTH, $clog2(ENTRY_NUM), PHT index width.
- DATA_WIDTH, 16, bits per PHT entry (8 two-bit counters).
- INIT_VALUE, 16'hAAAA, value written to each entry during the init sweep (every counter = 2).
- REQ_NUM, 2, update request ports and RAM write ports; fixed at 2.
- BANK_NUM, 2, RAM banks; bank = index[$clog2(BANK_NUM)-1:0].
- QUEUE_DEPTH, 8, update queue entries (power of two, ≥4).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- reqValid[REQ_NUM], in, 1 each, update request valid; port 0 is older than port 1.
- reqAddr[REQ_NUM], in, INDEX_WIDTH each, PHT index to update.
- reqData[REQ_NUM], in, DATA_WIDTH each, full new entry value.
- reqReady, out, 1, both request ports may present this cycle.
- we[REQ_NUM], out, 1 each, RAM write enables.
- wa[REQ_NUM], out, INDEX_WIDTH each, RAM write addresses.
- wv[REQ_NUM], out, DATA_WIDTH each, RAM write data.
- initBusy, out, 1, init sweep in progress; predictor reads are invalid.
- pendingCount, out, $clog2(QUEUE_DEPTH)+1, queue occupancy.
- dropCount, out, 8, saturating count of requests dropped because reqReady was low.

Behaviour:
- **Reset.** While rst=1: state←INIT, initPtr←0, queue and count cleared, dropCount←0. Outputs during rst: we=0, wa=0, wv=0, reqReady=0, initBusy=1, pendingCount=0.
- **Reset mid-operation.** Reset in the middle of INIT or RUN discards queued updates and restarts the sweep from index 0.
- **INIT state.**
  - Each cycle, write port p writes index initPtr+p with INIT_VALUE (we[0]=we[1]=1). The two writes always hit different banks.
  - initPtr increments by 2.
  - The sweep takes exactly ENTRY_NUM/2 cycles, starting in the first cycle after rst falls.
  - After the write of index ENTRY_NUM-1, state→RUN on the next edge; initBusy falls in that same cycle.
  - In INIT: reqReady=0, and any reqValid is dropped and counted.
- **RUN state: enqueue.**
  - reqReady = (count ≤ QUEUE_DEPTH-2), computed from the registered count; it is not reduced by same-cycle dequeues.
  - With reqReady=1, valid requests enqueue in port order (port 0 first).
  - If both ports are valid with equal reqAddr, only port 1 (younger) is enqueued.
- **Dropped requests.** A valid request seen while reqReady=0 is dropped. dropCount increments by the number dropped and saturates at 255.
- **RUN state: issue.** Combinational from the queue head registers.
  - If count≥1: we[0]=1, wa[0]/wv[0]=head entry.
  - If count≥2 and bank(head+1)≠bank(head): we[1]=1 with head+1. Otherwise we[1]=0.
  - Entries with the same address always share a bank, so program order per address is preserved.
  - Dequeue 1 or 2 entries accordingly.
- **Latency and simultaneous events.**
  - A request accepted in cycle N is written no earlier than cycle N+1.
  - Enqueue and dequeue in the same cycle are allowed; count_next = count + enq − deq.
- **Wrap-around.** Queue read/write pointers are $clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
- **Boundary states.**
  - Full (count=QUEUE_DEPTH) cannot occur while the producer honours reqReady.
  - Empty gives we=0.

Test Plan:
1. Assert rst for 3 cycles, then release with ENTRY_NUM=16 → exactly 8 cycles of paired writes to indices (0,1)…(14,15), all with 16'hAAAA. initBusy=1 throughout; it falls in cycle 9 with reqReady=1.
2. Queue empty; in one cycle present port0 addr 4, port1 addr 7 → next cycle we=2'b11, wa={4,7}, pendingCount returns to 0.
3. Present port0 addr 4, port1 addr 6 (same bank) → cycle+1 writes only 4 on port 0; cycle+2 writes 6 on port 0; order is preserved.
4. Present port0 addr 5 data 1, port1 addr 5 data 2 → a single write of addr 5 with data 2; pendingCount peaks at 1.
5. Present same-bank pairs every cycle until count=7 → reqReady=0; the next valid pair is not enqueued and dropCount=2; reqReady returns once count≤6.
6. Assert rst mid-RUN with 5 entries queued → queue flushes with no further update writes, and the init sweep restarts at index 0.
